regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32 x 32-bit register file between two requesters: port 0 (main pipeline write-back) and port 1 (multi-cycle unit write-back, e.g. mult/div or late load). It arbitrates valid/ready requests once per cycle and registers the winning write into a one-cycle write command. That command drives the register file's write enable, destination and data inputs. It also suppresses writes to register $0 and keeps a saturating conflict counter for performance monitoring.

---
 rtl/regfile_write_arbiter_if.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 tb/tb_regfile_write_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-request and register-file-command bundle for regfile_write_arbiter.
// slave = arbiter side, master = requesters / register file side.
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);
   logic              i_Valid0;
   logic [ADDR_W-1:0] i_Addr0;
   logic [DATA_W-1:0] i_Data0;
   logic              o_Ready0;
   logic              i_Valid1;
   logic [ADDR_W-1:0] i_Addr1;
   logic [DATA_W-1:0] i_Data1;
   logic              o_Ready1;
   logic              o_RegWrite;
   logic [ADDR_W-1:0] o_WriteAddr;
   logic [DATA_W-1:0] o_WriteData;
   logic [CNT_W-1:0]  o_Conflicts;

   modport slave (
      input  i_Valid0, i_Addr0, i_Data0, i_Valid1, i_Addr1, i_Data1,
      output o_Ready0, o_Ready1, o_RegWrite, o_WriteAddr, o_WriteData, o_Conflicts
   );

   modport master (
      output i_Valid0, i_Addr0, i_Data0, i_Valid1, i_Addr1, i_Data1,
      input  o_Ready0, o_Ready1, o_RegWrite, o_WriteAddr, o_WriteData, o_Conflicts
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-port arbiter for the register file write port with $0 suppression and conflict counter.
// RFARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed priority with starvation guard.
module regfile_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   regfile_write_arbiter_if.slave bus
);

   logic              grant0, grant1, xfer, prefer1;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  conf_q, conf_d;

`ifdef RFARB_ROUND_ROBIN_EN
   logic rr_q, rr_d;
`else
   logic [3:0] starve_q, starve_d;
`endif

   always_comb begin
`ifdef RFARB_ROUND_ROBIN_EN
      prefer1 = rr_q;
`else
      prefer1 = (starve_q == 4'(STARVE_LIMIT));
`endif
      // Readies are forced low while reset is asserted so nothing transfers during reset.
      grant1   = i_Rst_n && bus.i_Valid1 && (!bus.i_Valid0 || prefer1);
      grant0   = i_Rst_n && bus.i_Valid0 && !grant1;
      xfer     = grant0 || grant1;
      win_addr = grant1 ? bus.i_Addr1 : bus.i_Addr0;
      win_data = grant1 ? bus.i_Data1 : bus.i_Data0;

      regwrite_d = xfer && (win_addr != '0);
      waddr_d    = xfer ? win_addr : waddr_q;
      wdata_d    = xfer ? win_data : wdata_q;

      conf_d = conf_q;
      if (bus.i_Valid0 && bus.i_Valid1 && (conf_q != '1))
         conf_d = conf_q + CNT_W'(1);

`ifdef RFARB_ROUND_ROBIN_EN
      rr_d = xfer ? grant0 : rr_q;
`else
      starve_d = 4'd0;
      if (bus.i_Valid1 && !grant1)
         starve_d = (starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1;
`endif
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         regwrite_q <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         conf_q     <= '0;
`ifdef RFARB_ROUND_ROBIN_EN
         rr_q       <= 1'b0;
`else
         starve_q   <= 4'd0;
`endif
      end else begin
         regwrite_q <= regwrite_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         conf_q     <= conf_d;
`ifdef RFARB_ROUND_ROBIN_EN
         rr_q       <= rr_d;
`else
         starve_q   <= starve_d;
`endif
      end
   end

   assign bus.o_Ready0    = grant0;
   assign bus.o_Ready1    = grant1;
   assign bus.o_RegWrite  = regwrite_q;
   assign bus.o_WriteAddr = waddr_q;
   assign bus.o_WriteData = wdata_q;
   assign bus.o_Conflicts = conf_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus reset, starvation and saturation sequences.
module tb_regfile_write_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 16;
   localparam int SL = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL), .CNT_W(CW)) dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   // Register file model fed by the DUT command; no $0 protection so a bad write shows up.
   logic [DW-1:0] rf [32];
   logic          rf_clear = 1'b1;
   always @(posedge clk) begin
      if (rf_clear) begin
         for (int k = 0; k < 32; k++) rf[k] <= '0;
      end else if (bus.o_RegWrite) begin
         rf[bus.o_WriteAddr] <= bus.o_WriteData;
      end
   end

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      bus.i_Valid0 = v0; bus.i_Addr0 = a0; bus.i_Data0 = d0;
      bus.i_Valid1 = v1; bus.i_Addr1 = a1; bus.i_Data1 = d1;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   typedef struct {
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          r0;
      logic          r1;
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [CW-1:0] conf;
   } vec_t;

   localparam int NV = 10;
   vec_t tbl [NV];

   initial begin
      logic exp_r1;
      logic [AW-1:0] exp_wa;

      //        v0  a0     d0            v1  a1     d1            r0  r1  we  wa     wd            conf
      tbl[0] = '{1'b1, 5'd1, 32'h11,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd1, 32'h11,       16'd0};
      tbl[1] = '{1'b1, 5'd2, 32'h22,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd2, 32'h22,       16'd0};
      tbl[2] = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd3, 32'h33,       16'd0};
      tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd3, 32'h33,       16'd0};
      tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h55,       1'b0, 1'b1, 1'b1, 5'd5, 32'h55,       16'd0};
      tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 16'd0};
      tbl[6] = '{1'b1, 5'd7, 32'hA,        1'b1, 5'd7, 32'hB,        1'b1, 1'b0, 1'b1, 5'd7, 32'hA,        16'd1};
      tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'hB,        1'b0, 1'b1, 1'b1, 5'd7, 32'hB,        16'd1};
      tbl[8] = '{1'b1, 5'd0, 32'h5,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 32'h5,        16'd1};
      tbl[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h5,        16'd1};

      // Reset held with both requests pending.
      drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444);
      repeat (3) @(posedge clk);
      #1;
      chk("rst ready0", bus.o_Ready0, 0);
      chk("rst ready1", bus.o_Ready1, 0);
      chk("rst regwrite", bus.o_RegWrite, 0);
      chk("rst waddr", bus.o_WriteAddr, 0);
      chk("rst wdata", bus.o_WriteData, 0);
      chk("rst conflicts", bus.o_Conflicts, 0);
      @(negedge clk);
      rf_clear = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("post-rst ready0", bus.o_Ready0, 1);
      chk("post-rst ready1", bus.o_Ready1, 0);
      @(posedge clk); #1;
      chk("post-rst regwrite", bus.o_RegWrite, 1);
      chk("post-rst waddr", bus.o_WriteAddr, 3);
      chk("post-rst wdata", bus.o_WriteData, 32'h3333);
      chk("post-rst conflicts", bus.o_Conflicts, 1);
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b1, 5'd4, 32'h4444);
      #1 chk("post-rst ready1 later", bus.o_Ready1, 1);
      @(posedge clk); #1;
      chk("post-rst p1 waddr", bus.o_WriteAddr, 4);

      // Vector table from a clean reset.
      reset_pulse();
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
         #1;
         chk($sformatf("vec%0d ready0", i), bus.o_Ready0, tbl[i].r0);
         chk($sformatf("vec%0d ready1", i), bus.o_Ready1, tbl[i].r1);
         @(posedge clk); #1;
         chk($sformatf("vec%0d regwrite", i), bus.o_RegWrite, tbl[i].we);
         chk($sformatf("vec%0d waddr", i), bus.o_WriteAddr, tbl[i].wa);
         chk($sformatf("vec%0d wdata", i), bus.o_WriteData, tbl[i].wd);
         chk($sformatf("vec%0d conflicts", i), bus.o_Conflicts, tbl[i].conf);
      end
      @(posedge clk); #1;
      chk("rf[7] final", rf[7], 32'hB);
      chk("rf[3]", rf[3], 32'h33);
      chk("rf[0] stays zero", rf[0], 0);

      // Port 0 saturating the bus while port 1 waits for reg 9.
      reset_pulse();
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         drive(1'b1, 5'd1, DW'(c), 1'b1, 5'd9, 32'h99);
`ifdef RFARB_ROUND_ROBIN_EN
         exp_r1 = (c % 2 == 0);
`else
         exp_r1 = (c == SL + 1);
`endif
         #1;
         chk($sformatf("starve cyc%0d ready1", c), bus.o_Ready1, exp_r1);
         chk($sformatf("starve cyc%0d ready0", c), bus.o_Ready0, !exp_r1);
         @(posedge clk); #1;
      end
`ifdef RFARB_ROUND_ROBIN_EN
      exp_wa = 5'd1;
`else
      exp_wa = 5'd9;
`endif
      chk("starve last waddr", bus.o_WriteAddr, exp_wa);
      chk("starve conflicts", bus.o_Conflicts, 5);

      // Conflict counter saturation, then asynchronous clear mid-cycle.
      reset_pulse();
      @(negedge clk);
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      repeat ((1 << CW) + 10) @(posedge clk);
      #1;
      chk("conflicts saturated", bus.o_Conflicts, 16'hFFFF);
      #2 rst_n = 1'b0;
      #1;
      chk("async clear conflicts", bus.o_Conflicts, 0);
      chk("async clear regwrite", bus.o_RegWrite, 0);
      chk("async clear ready0", bus.o_Ready0, 0);
      chk("async clear ready1", bus.o_Ready1, 0);
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
